qk_adder_sequencer: RTL and testbench

Control FSM that sequences the 4x4 Q·K partial-product adder through its two-pass combine for each output tile: pass 1 adds INT<<8 to Frac1, pass 2 adds the held result to Frac2. It sits between the systolic-array result producers and the downstream softmax stage. It drives the adder's `enable`/`IntFlag` and the operand muxes, and it holds the adder's registered result while waiting. Results are handed to the consumer through a valid/ready handshake, one tile at a time, for `NUM_TILES` tiles per `start`.

---
 rtl/qk_adder_sequencer.sv | 135 +++++++++++++
 tb/tb_qk_adder_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/qk_adder_sequencer.sv
// qk_adder_sequencer: control FSM for the two-pass Q.K tile adder.
// Optional abort input enabled by defining QK_ADDER_SEQ_ABORT_EN.
module qk_adder_sequencer #(
   parameter int NUM_TILES = 4
) (
   input  logic       clk,
   input  logic       _reset,
   input  logic       start,
   input  logic       int_valid,
   input  logic       frac1_valid,
   input  logic       frac2_valid,
   input  logic       res_ready,
`ifdef QK_ADDER_SEQ_ABORT_EN
   input  logic       abort,
`endif
   output logic       enable,
   output logic       IntFlag,
   output logic       sel_in1,
   output logic [1:0] sel_in2,
   output logic       int_ack,
   output logic       frac1_ack,
   output logic       frac2_ack,
   output logic       res_valid,
   output logic [7:0] tile_idx,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_A,
      S_ADD1,
      S_WAIT_B,
      S_ADD2,
      S_RESULT,
      S_DONE
   } state_e;

   localparam logic [7:0] LAST_IDX = 8'(NUM_TILES - 1);

   state_e     state_q, state_d;
   logic [7:0] tile_q, tile_d;
   logic       abort_w;

`ifdef QK_ADDER_SEQ_ABORT_EN
   assign abort_w = abort && (state_q != S_IDLE);
`else
   assign abort_w = 1'b0;
`endif

   // State and tile counter registers
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state_q <= S_IDLE;
         tile_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         tile_q  <= tile_d;
      end
   end

   // Next-state logic and Moore decode of adder controls
   always_comb begin
      state_d   = state_q;
      tile_d    = tile_q;
      enable    = 1'b0;
      IntFlag   = 1'b0;
      sel_in1   = 1'b0;
      sel_in2   = 2'd2;
      int_ack   = 1'b0;
      frac1_ack = 1'b0;
      frac2_ack = 1'b0;
      res_valid = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WAIT_A;
               tile_d  = 8'd0;
            end
         end
         S_WAIT_A: begin
            if (int_valid && frac1_valid)
               state_d = S_ADD1;
         end
         S_ADD1: begin
            enable    = 1'b1;
            IntFlag   = 1'b1;
            sel_in1   = 1'b0;
            sel_in2   = 2'd0;
            int_ack   = !abort_w;
            frac1_ack = !abort_w;
            state_d   = frac2_valid ? S_ADD2 : S_WAIT_B;
         end
         S_WAIT_B: begin
            if (frac2_valid)
               state_d = S_ADD2;
         end
         S_ADD2: begin
            enable    = 1'b1;
            IntFlag   = 1'b0;
            sel_in1   = 1'b1;
            sel_in2   = 2'd1;
            frac2_ack = !abort_w;
            state_d   = S_RESULT;
         end
         S_RESULT: begin
            res_valid = 1'b1;
            if (res_ready) begin
               if (tile_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  tile_d  = tile_q + 8'd1;
                  state_d = S_WAIT_A;
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (abort_w) begin
         state_d = S_IDLE;
         tile_d  = 8'd0;
      end
   end

   assign tile_idx = tile_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_qk_adder_sequencer.sv
// tb_qk_adder_sequencer: directed checks of the Q.K adder sequencer.
// Runs a 4-tile job with a behavioural adder plus a 1-tile timing job.
module tb_qk_adder_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, int_valid, frac1_valid, frac2_valid, res_ready;

   logic       en4, if4, s1_4, ia4, f1a4, f2a4, rv4, bz4, dn4;
   logic [1:0] s2_4;
   logic [7:0] ti4;

   logic       en1, if1, s1_1, ia1, f1a1, f2a1, rv1, bz1, dn1;
   logic [1:0] s2_1;
   logic [7:0] ti1;

   logic [15:0] a_int, a_f1, a_f2, acc, in1, in2;

   int n_chk  = 0;
   int n_pass = 0;
   int n_done = 0;

   always #5 clk = ~clk;

   qk_adder_sequencer #(.NUM_TILES(4)) u4 (
      .clk(clk), ._reset(rst_n), .start(start),
      .int_valid(int_valid), .frac1_valid(frac1_valid),
      .frac2_valid(frac2_valid), .res_ready(res_ready),
      .enable(en4), .IntFlag(if4), .sel_in1(s1_4), .sel_in2(s2_4),
      .int_ack(ia4), .frac1_ack(f1a4), .frac2_ack(f2a4),
      .res_valid(rv4), .tile_idx(ti4), .busy(bz4), .done(dn4)
   );

   qk_adder_sequencer #(.NUM_TILES(1)) u1 (
      .clk(clk), ._reset(rst_n), .start(start),
      .int_valid(int_valid), .frac1_valid(frac1_valid),
      .frac2_valid(frac2_valid), .res_ready(res_ready),
      .enable(en1), .IntFlag(if1), .sel_in1(s1_1), .sel_in2(s2_1),
      .int_ack(ia1), .frac1_ack(f1a1), .frac2_ack(f2a1),
      .res_valid(rv1), .tile_idx(ti1), .busy(bz1), .done(dn1)
   );

   // Behavioural two-input adder driven by the 4-tile sequencer
   always_comb begin
      in1 = s1_4 ? acc : a_int;
      case (s2_4)
         2'd0:    in2 = a_f1;
         2'd1:    in2 = a_f2;
         default: in2 = acc;
      endcase
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= 16'd0;
      else if (en4)
         acc <= (if4 ? (in1 << 8) : in1) + in2;
      else
         acc <= in2;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(negedge clk);
      if (dn4) n_done++;
   endtask

   task automatic set_ops(input logic [15:0] i, f1, f2);
      a_int = i;
      a_f1  = f1;
      a_f2  = f2;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      int_valid = 1'b0;
      frac1_valid = 1'b0;
      frac2_valid = 1'b0;
      res_ready = 1'b0;
      set_ops(16'd0, 16'd0, 16'd0);
      step();
      step();
      chk("rst_enable", en4, 1'b0);
      chk("rst_sel_in2", s2_4, 2'd2);
      chk("rst_busy", bz4, 1'b0);
      chk("rst_tile", ti4, 8'd0);
      chk("rst_acks", {ia4, f1a4, f2a4}, 3'b000);
      chk("rst_rv_done", {rv4, dn4}, 2'b00);
      rst_n = 1'b1;
      step();
      chk("idle_busy", bz4, 1'b0);

      // cycle 0: start with every valid high
      int_valid = 1'b1;
      frac1_valid = 1'b1;
      frac2_valid = 1'b1;
      res_ready = 1'b1;
      set_ops(16'd3, 16'h10, 16'h20);
      start = 1'b1;
      n_done = 0;
      step();
      start = 1'b0;
      chk("c1_busy", {bz4, bz1}, 2'b11);
      chk("c1_wait_en", en4, 1'b0);
      chk("c1_tile", ti4, 8'd0);
      step();
      chk("c2_add1_en", {en1, en4}, 2'b11);
      chk("c2_add1_ctl", {if4, s1_4, s2_4}, 4'b1000);
      chk("c2_add1_ack", {ia4, f1a4, f2a4}, 3'b110);
      step();
      chk("c3_add2_ctl", {en4, if4, s1_4, s2_4}, 5'b10101);
      chk("c3_add2_ack", {ia4, f1a4, f2a4}, 3'b001);
      step();
      chk("c4_res_valid", {rv1, rv4}, 2'b11);
      chk("c4_sum", acc, 16'h0330);
      step();
      chk("c5_u1_done", dn1, 1'b1);
      chk("c5_tile", ti4, 8'd1);
      chk("c5_rv_low", rv4, 1'b0);
      set_ops(16'd1, 16'd2, 16'd5);
      frac2_valid = 1'b0;
      step();
      chk("c6_u1_busy", bz1, 1'b0);
      chk("c6_add1_en", en4, 1'b1);

      // tile 1 stalls in WAIT_B; start pulse mid-job must be ignored
      for (int i = 0; i < 5; i++) begin
         step();
         chk("waitb_en", en4, 1'b0);
         chk("waitb_sel", s2_4, 2'd2);
         chk("waitb_hold", acc, 16'h0102);
         chk("waitb_tile", ti4, 8'd1);
         chk("waitb_busy", bz4, 1'b1);
         start = (i == 1);
         if (i == 4) frac2_valid = 1'b1;
      end
      step();
      chk("c12_add2_ack", f2a4, 1'b1);
      step();
      chk("c13_rv", rv4, 1'b1);
      chk("c13_sum", acc, 16'h0107);
      chk("c13_tile", ti4, 8'd1);
      set_ops(16'd0, 16'h40, 16'd1);
      step();
      chk("c14_tile", ti4, 8'd2);
      chk("c14_rv", rv4, 1'b0);
      res_ready = 1'b0;
      step();
      step();

      // tile 2 waits for res_ready across four RESULT cycles
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stall_rv", rv4, 1'b1);
         chk("stall_sum", acc, 16'h0041);
         chk("stall_tile", ti4, 8'd2);
         if (i == 0) set_ops(16'd2, 16'd0, 16'd0);
         if (i == 3) res_ready = 1'b1;
      end
      step();
      chk("c21_rv", rv4, 1'b0);
      chk("c21_tile", ti4, 8'd3);
      step();
      step();
      step();
      chk("c24_rv", rv4, 1'b1);
      chk("c24_sum", acc, 16'h0200);
      chk("c24_done", dn4, 1'b0);
      step();
      chk("c25_done", dn4, 1'b1);
      step();
      chk("c26_busy", bz4, 1'b0);
      chk("c26_tile", ti4, 8'd3);
      chk("done_count", n_done, 1);

      // asynchronous reset in the middle of tile 1
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      step();
      chk("pre_rst_tile", ti4, 8'd1);
      step();
      chk("pre_rst_en", en4, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_en", {en4, if4}, 2'b00);
      chk("arst_ack", {ia4, f1a4}, 2'b00);
      chk("arst_sel", {s1_4, s2_4}, 3'b010);
      chk("arst_busy", bz4, 1'b0);
      chk("arst_tile", ti4, 8'd0);
      step();
      rst_n = 1'b1;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
